// File: rtl/thermal_monitor_mc_if.sv
// thermal_monitor_mc_if: sensor readings, control inputs and status outputs of the
// multi-channel thermal supervisor; master drives sensors/controls, slave is the supervisor.
interface thermal_monitor_mc_if #(
    parameter int N_CH = 4,
    parameter int TW   = 12,
    parameter int IW   = 2
);
    logic [N_CH-1:0]    temp_rdy;
    logic [N_CH*TW-1:0] temp_bus;
    logic [N_CH-1:0]    ch_enable;
    logic [TW-1:0]      warn_temp;
    logic [TW-1:0]      warn_hyst;
    logic [TW-1:0]      shutdown_temp;
    logic               shutdown_clr;
    logic               peak_clr;
    logic [N_CH-1:0]    warn;
    logic               thermal_shutdown;
    logic [IW-1:0]      trip_ch;
    logic [TW-1:0]      peak_temp;

    modport master (
        output temp_rdy, temp_bus, ch_enable, warn_temp, warn_hyst, shutdown_temp,
               shutdown_clr, peak_clr,
        input  warn, thermal_shutdown, trip_ch, peak_temp
    );
    modport slave (
        input  temp_rdy, temp_bus, ch_enable, warn_temp, warn_hyst, shutdown_temp,
               shutdown_clr, peak_clr,
        output warn, thermal_shutdown, trip_ch, peak_temp
    );
endinterface

// File: rtl/thermal_monitor_mc.sv
// thermal_monitor_mc: per-channel persistence-qualified over-temperature shutdown latch,
// hysteretic warnings and peak tracking across N_CH sensor channels.
module thermal_monitor_mc #(
    parameter int N_CH        = 4,
    parameter int TW          = 12,
    parameter int PERSIST_CNT = 20000000,
    parameter int CW          = 28,
    parameter int IW          = 2
) (
    input  logic clk,
    input  logic rst,
    thermal_monitor_mc_if.slave bus
);
    logic [N_CH-1:0] sync1_q, sync2_q, warn_q, warn_d, q, over;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [TW-1:0]   temp [N_CH];
    logic [TW-1:0]   peak_q, peak_d, rel;
    logic [IW-1:0]   trip_q, trip_d, trip_idx;
    logic            ts_q, ts_d, any_over, any_trip;

    genvar i;
    for (i = 0; i < N_CH; i++) begin : g_temp
        assign temp[i] = bus.temp_bus[i*TW +: TW];
    end

    always_comb begin
        rel      = (bus.warn_temp >= bus.warn_hyst) ? bus.warn_temp - bus.warn_hyst : '0;
        q        = '0;
        over     = '0;
        warn_d   = warn_q;
        cnt_d    = cnt_q;
        any_over = 1'b0;
        any_trip = 1'b0;
        trip_idx = '0;
        peak_d   = bus.peak_clr ? '0 : peak_q;
        // Descending scan so the lowest tripping channel is the last one written.
        for (int k = N_CH - 1; k >= 0; k--) begin
            q[k]      = sync2_q[k] & bus.ch_enable[k];
            over[k]   = q[k] && (temp[k] > bus.shutdown_temp);
            cnt_d[k]  = !over[k] ? '0 : (cnt_q[k] == CW'(PERSIST_CNT)) ? cnt_q[k] : cnt_q[k] + 1'b1;
            warn_d[k] = !bus.ch_enable[k] ? 1'b0 : !q[k] ? warn_q[k] :
                        (temp[k] > bus.warn_temp) ? 1'b1 : (temp[k] < rel) ? 1'b0 : warn_q[k];
            any_over  = any_over | over[k];
            if (over[k] && cnt_q[k] == CW'(PERSIST_CNT)) begin
                any_trip = 1'b1;
                trip_idx = IW'(k);
            end
            if (q[k] && temp[k] > peak_d) peak_d = temp[k];
        end
        ts_d   = ts_q;
        trip_d = trip_q;
        if (!ts_q && any_trip) begin
            ts_d   = 1'b1;
            trip_d = trip_idx;
        end else if (bus.shutdown_clr && !any_over) begin
            ts_d   = 1'b0;
            trip_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            warn_q  <= '0;
            peak_q  <= '0;
            trip_q  <= '0;
            ts_q    <= 1'b0;
            for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q <= bus.temp_rdy;
            sync2_q <= sync1_q;
            warn_q  <= warn_d;
            peak_q  <= peak_d;
            trip_q  <= trip_d;
            ts_q    <= ts_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.warn             = warn_q;
    assign bus.thermal_shutdown = ts_q;
    assign bus.trip_ch          = trip_q;
    assign bus.peak_temp        = peak_q;
endmodule

// File: doc/thermal_monitor_mc.md
Name: thermal_monitor_mc

Overview:
- Multi-channel thermal supervisor. Generalises single-sensor over-temperature shutdown to N_CH sensor channels.
- Adds per-channel warning flags with hysteresis, per-channel enables, a latched shutdown with conditional clear, trip-channel capture, and peak-temperature tracking.
- Sits between the temperature readout logic (XADC/device temp plus board sensors) and the power-control/slow-control register map.

Parameters:
- N_CH, 4, number of temperature channels.
- TW, 12, temperature code width; all codes are unsigned.
- PERSIST_CNT, 20000000, consecutive qualifying cycles before a trip (1 s at 20 MHz).
- CW, 28, persistence counter width; must hold PERSIST_CNT.
- IW, 2, trip channel index width; must satisfy 2^IW >= N_CH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- temp_rdy  in  N_CH  per-channel data-valid level, asynchronous to clk.
- temp_bus  in  N_CH*TW  channel k occupies bits [k*TW +: TW]; stable whenever temp_rdy[k] is high.
- ch_enable  in  N_CH  channel participates in shutdown, warning and peak logic when 1.
- warn_temp  in  TW  warning threshold.
- warn_hyst  in  TW  warning release hysteresis.
- shutdown_temp  in  TW  shutdown threshold.
- shutdown_clr  in  1  single-cycle request to clear the shutdown latch.
- peak_clr  in  1  single-cycle request to clear peak_temp.
- warn  out  N_CH  per-channel warning flags.
- thermal_shutdown  out  1  latched shutdown.
- trip_ch  out  IW  index of the channel that caused the shutdown.
- peak_temp  out  TW  highest qualified temperature since the last clear.

Behaviour:
- Reset values: warn=0, thermal_shutdown=0, trip_ch=0, peak_temp=0, all counters=0, all synchroniser flops=0.
- Synchronisation: each temp_rdy[k] passes through a 2-flop synchroniser, giving rdy_s[k] 2 cycles later.
- Qualification: q[k] = rdy_s[k] & ch_enable[k].
- Over-condition: over[k] = q[k] & (temp_k > shutdown_temp), strictly greater.
- Persistence counter cnt[k]:
  - Increments on each edge where over[k]=1, saturating at PERSIST_CNT.
  - Returns to 0 on any edge where over[k]=0. There is no accumulation across gaps.
- Trip: on any edge where some cnt[k] == PERSIST_CNT (pre-edge value) and over[k]=1:
  - thermal_shutdown <= 1.
  - trip_ch <= lowest such k.
  - This applies only if thermal_shutdown was 0; once latched, trip_ch is frozen.
- Trip latency: after over[k] rises, thermal_shutdown rises on the (PERSIST_CNT+1)th consecutive qualifying edge.
- Clear: shutdown_clr=1 clears thermal_shutdown and trip_ch only if no over[k] is 1 in that cycle; otherwise the request is ignored (no queuing).
  - If a trip and a clear occur on the same edge, the trip wins.
  - Counters are unaffected by a clear.
- Warning, per channel, updated only when q[k]=1:
  - Set when temp_k > warn_temp.
  - Cleared when temp_k < rel, where rel = warn_temp - warn_hyst, saturating at 0. With rel=0 the flag never clears by temperature.
  - Otherwise held.
  - When q[k]=0, warn[k] holds its value.
  - When ch_enable[k]=0, warn[k] is forced to 0 on the next edge.
- Peak: on each edge, peak_temp <= max(peak_temp, max over k with q[k]=1 of temp_k).
  - peak_clr=1 loads 0 and then applies the same-cycle max: clear first, then compare.
- Registered outputs: all outputs are registered with 1-cycle latency from the qualifying edge. There are no combinational paths from inputs to outputs.
- rst asserted mid-count or while latched: everything returns to reset values on that edge.

Test Plan (PERSIST_CNT=10, N_CH=4):
- Single-channel trip:
  - Stimulus: ch1 temp=0x900, shutdown_temp=0x800, temp_rdy[1] held high, all enabled.
  - Required: thermal_shutdown rises exactly 13 edges after temp_rdy[1] rises (2 sync + 11), and trip_ch=1.
- Interrupted persistence:
  - Stimulus: same as above, but temp_rdy[1] drops for 1 cycle after 8 qualifying cycles, then resumes.
  - Required: no trip until 11 further consecutive qualifying edges; trip occurs only then.
- Simultaneous trip:
  - Stimulus: ch2 and ch3 over-threshold starting on the same cycle.
  - Required: trip_ch=2. Thermal_shutdown stays latched, and trip_ch stays 2, after both channels cool to 0x700.
- Clear gating and priority:
  - Stimulus 1: shutdown_clr while ch0 is still over.
  - Required: ignored, thermal_shutdown stays 1.
  - Stimulus 2: shutdown_clr after ch0 cools.
  - Required: thermal_shutdown=0 and trip_ch=0.
  - Stimulus 3: clear on the same edge as a new trip.
  - Required: thermal_shutdown=1.
- Warning hysteresis:
  - Stimulus: warn_temp=0x600, warn_hyst=0x040; ch0 sequence 0x5F0, 0x610, 0x5D0, 0x5BF.
  - Required: warn[0] = 0, 1, 1, 0.
  - Stimulus: ch_enable[0]=0.
  - Required: warn[0]=0 on the next edge; ch0 contributes no count and no peak update.
- Peak and reset:
  - Stimulus: ch0=0x500, ch3=0x650 qualified.
  - Required: peak_temp=0x650.
  - Stimulus: peak_clr with ch0=0x400 qualified in the same cycle.
  - Required: peak_temp=0x400.
  - Stimulus: rst asserted with cnt=5.
  - Required: all outputs 0; a fresh full persistence period is needed to trip.
